msrv32_dbus_ctrl: RTL
=====================

Name: msrv32_dbus_ctrl

Overview:
Data-bus controller between the execute stage and the load unit. Accepts one load/store request at a time and runs it as a single AHB-Lite transfer: address phase, data phase, and wait states. It captures read data, response and alignment info in registers and feeds them to the load unit. It rejects misaligned or illegal-size requests without touching the bus, and aborts a transfer that stalls too long.

Parameters:
TIMEOUT_CYCLES, 16, consecutive hready_in-low cycles (ADDR or DATA) before abort; legal range 2..255.

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  asynchronous active-low reset
req_valid_in  input  1  request present
req_ready_out  output  1  controller can accept request (high only in IDLE)
req_addr_in  input  32  byte address
req_we_in  input  1  1 = store, 0 = load
req_size_in  input  2  00 byte, 01 half, 11 word, 10 illegal
req_unsigned_in  input  1  load extension select, forwarded untouched
req_wdata_in  input  32  store data, right-justified
haddr_out  output  32  AHB address
htrans_out  output  2  00 IDLE, 10 NONSEQ
hwrite_out  output  1  AHB write
hsize_out  output  3  000/001/010
hwdata_out  output  32  AHB write data, lane-replicated
wmask_out  output  4  byte-lane write strobes, valid in DATA
hready_in  input  1  AHB ready
hresp_in  input  1  AHB error response
hrdata_in  input  32  AHB read data
lu_data_out  output  32  captured read data (to load unit data_in)
lu_load_size_out  output  2  captured size (to load unit load_size_in)
lu_unsigned_out  output  1  captured unsigned flag
lu_addr_lo_out  output  2  captured addr[1:0]
lu_resp_out  output  1  captured error (to load unit ahb_resp_in)
done_valid_out  output  1  one-cycle completion pulse
misalign_out  output  1  one-cycle pulse: request rejected
timeout_out  output  1  one-cycle pulse: transfer aborted

Behaviour:
- Reset (async, rst_n_in low): state IDLE. htrans_out=00. All registered outputs, the counter and the captured lu_* fields clear to 0. req_ready_out=1 (decoded from IDLE).
- Reset asserted mid-transfer: bus drops to IDLE immediately. No done_valid_out pulse.
- States: IDLE, ADDR, DATA.
- IDLE: accept when req_valid_in && req_ready_out.
  - Reject if size=10, or half with addr[0]=1, or word with addr[1:0]!=0. Pulse misalign_out next cycle, stay IDLE, no bus activity, lu_* unchanged.
  - Otherwise latch addr, we, size, unsigned and wdata, then go to ADDR.
- ADDR: haddr_out=latched addr. htrans_out=10. hwrite_out=we. hsize_out=000/001/010 for byte/half/word.
  - hready_in=1: go to DATA.
  - hready_in=0: hold all address-phase signals stable.
- DATA: htrans_out=00.
  - hwdata_out lanes: byte replicated x4, half replicated x2, word as-is.
  - wmask_out for stores: byte = 0001<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111. wmask_out=0000 for loads and outside DATA.
  - hready_in=1: capture hrdata_in (loads only; stores leave lu_data_out unchanged), size, unsigned, addr[1:0] and lu_resp_out=hresp_in. Pulse done_valid_out next cycle. Go to IDLE.
- AHB error: the two-cycle error (hresp_in=1 with hready_in=0, then hresp_in=1 with hready_in=1) is sampled only on the hready_in=1 cycle. The first cycle counts as a wait state.
- Latency, zero-wait-state transfer:
  - accept edge at cycle 0;
  - ADDR in cycle 1, DATA in cycle 2;
  - done_valid_out and req_ready_out both high in cycle 3.
  - Throughput is 1 transfer per 3 cycles. Each wait state adds 1 cycle.
- Timeout:
  - An 8-bit counter increments on each hready_in=0 cycle in ADDR or DATA. It clears on hready_in=1 and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, htrans_out=00, set lu_resp_out=1, lu_data_out unchanged, pulse done_valid_out and timeout_out together.
- Output stability: lu_* fields hold until the next completion. done_valid_out, misalign_out and timeout_out are never high together except the timeout pair.
- Requests arriving outside IDLE are ignored. The requester holds req_valid_in until ready.

Test Plan:
- Load word, addr 0x100, zero wait, hrdata 0xDEADBEEF -> htrans 10 in cycle 1, done cycle 3, lu_data_out=0xDEADBEEF, lu_load_size_out=11, lu_resp_out=0.
- Store byte 0xA5, addr 0x203, 2 wait states in DATA -> hsize 000, hwdata 0xA5A5A5A5, wmask 1000 held 3 cycles, done cycle 5.
- Load half, addr 0x001 -> misalign_out pulse, htrans stays 00, no done_valid_out. Size 10 at addr 0x0 -> same result.
- Load, AHB two-cycle error in DATA -> done_valid_out on the cycle after the hready high, lu_resp_out=1.
- hready_in held low in ADDR, TIMEOUT_CYCLES=16 -> abort after 16 low cycles, done_valid_out=timeout_out=1, lu_resp_out=1, state IDLE. Then a back-to-back word load completes normally.
- rst_n_in low during DATA of a store -> htrans 00, wmask 0000, outputs cleared, no done pulse. The first request after reset is accepted.

Source files
------------

// File: rtl/msrv32_dbus_ctrl.sv
// Data-bus controller: runs one load/store request as a single AHB-Lite
// transfer (address phase, data phase, wait states). It captures read data,
// response and alignment info for the load unit, rejects misaligned or
// illegal-size requests without touching the bus, and aborts a transfer
// that stalls too long.
module msrv32_dbus_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] req_addr_in,
    input  logic        req_we_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_wdata_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  wmask_out,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic [31:0] lu_data_out,
    output logic [1:0]  lu_load_size_out,
    output logic        lu_unsigned_out,
    output logic [1:0]  lu_addr_lo_out,
    output logic        lu_resp_out,
    output logic        done_valid_out,
    output logic        misalign_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  wait_cnt_next;
    logic        timeout_hit;
    logic        req_bad;

    logic [31:0] lu_data_reg;
    logic [1:0]  lu_size_reg;
    logic        lu_unsigned_reg;
    logic [1:0]  lu_addr_lo_reg;
    logic        lu_resp_reg;
    logic        done_reg;
    logic        misalign_reg;
    logic        timeout_reg;

    // Request legality and stall-counter lookahead.
    always_comb begin
        req_bad = (req_size_in == 2'b10) ||
                  (req_size_in == 2'b01 && req_addr_in[0]) ||
                  (req_size_in == 2'b11 && req_addr_in[1:0] != 2'b00);
        wait_cnt_next = wait_cnt_reg + 8'd1;
        timeout_hit   = (wait_cnt_next == TIMEOUT_LIMIT);
    end

    // Transfer sequencer: accept/reject, phase tracking, capture and abort.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            we_reg          <= 1'b0;
            size_reg        <= 2'b00;
            unsigned_reg    <= 1'b0;
            wait_cnt_reg    <= '0;
            lu_data_reg     <= '0;
            lu_size_reg     <= 2'b00;
            lu_unsigned_reg <= 1'b0;
            lu_addr_lo_reg  <= 2'b00;
            lu_resp_reg     <= 1'b0;
            done_reg        <= 1'b0;
            misalign_reg    <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    wait_cnt_reg <= '0;
                    if (req_valid_in) begin
                        if (req_bad) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            addr_reg     <= req_addr_in;
                            wdata_reg    <= req_wdata_in;
                            we_reg       <= req_we_in;
                            size_reg     <= req_size_in;
                            unsigned_reg <= req_unsigned_in;
                            state_reg    <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (hready_in) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                    end else if (timeout_hit) begin
                        wait_cnt_reg <= '0;
                        lu_resp_reg  <= 1'b1;
                        done_reg     <= 1'b1;
                        timeout_reg  <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                ST_DATA: begin
                    // hresp_in only counts on the hready_in=1 cycle; the first
                    // error cycle is treated as an ordinary wait state.
                    if (hready_in) begin
                        if (!we_reg) begin
                            lu_data_reg <= hrdata_in;
                        end
                        lu_size_reg     <= size_reg;
                        lu_unsigned_reg <= unsigned_reg;
                        lu_addr_lo_reg  <= addr_reg[1:0];
                        lu_resp_reg     <= hresp_in;
                        done_reg        <= 1'b1;
                        wait_cnt_reg    <= '0;
                        state_reg       <= ST_IDLE;
                    end else if (timeout_hit) begin
                        wait_cnt_reg <= '0;
                        lu_resp_reg  <= 1'b1;
                        done_reg     <= 1'b1;
                        timeout_reg  <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                default: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    // Transfer size encoding for the address phase.
    always_comb begin
        case (size_reg)
            2'b00:   hsize_out = 3'b000;
            2'b01:   hsize_out = 3'b001;
            default: hsize_out = 3'b010;
        endcase
    end

    // Per-lane write data replication and write strobes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign hwdata_out[gi*8 +: 8] =
                (size_reg == 2'b00) ? wdata_reg[7:0] :
                (size_reg == 2'b01) ? wdata_reg[(gi % 2)*8 +: 8] :
                                      wdata_reg[gi*8 +: 8];
            assign wmask_out[gi] = (state_reg == ST_DATA) && we_reg &&
                ((size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                 (size_reg == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                       1'b1);
        end
    endgenerate

    assign req_ready_out    = (state_reg == ST_IDLE);
    assign haddr_out        = addr_reg;
    assign htrans_out       = (state_reg == ST_ADDR) ? 2'b10 : 2'b00;
    assign hwrite_out       = (state_reg == ST_ADDR) && we_reg;
    assign lu_data_out      = lu_data_reg;
    assign lu_load_size_out = lu_size_reg;
    assign lu_unsigned_out  = lu_unsigned_reg;
    assign lu_addr_lo_out   = lu_addr_lo_reg;
    assign lu_resp_out      = lu_resp_reg;
    assign done_valid_out   = done_reg;
    assign misalign_out     = misalign_reg;
    assign timeout_out      = timeout_reg;

endmodule
